// File: rtl/bram1be_client_pkg.sv
// -----------------------------------------------------------------------------
// bram1be_client_pkg
// Shared helpers for the byte-enabled BRAM client and its response FIFO.
//   ptr_width(depth)        : ring pointer width for a power-of-two depth
//   read_latency(pipelined) : BRAM read latency in cycles (1, or 2 with the
//                             BRAM output register enabled)
// -----------------------------------------------------------------------------
package bram1be_client_pkg;

    // log2 of a power-of-two depth, never less than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int read_latency(input int pipelined);
        return 1 + ((pipelined != 0) ? 1 : 0);
    endfunction

endpackage : bram1be_client_pkg

// File: rtl/bram1be_rsp_fifo.sv
// -----------------------------------------------------------------------------
// bram1be_rsp_fifo
// Power-of-two ring FIFO with occupancy count and a registered head word.
// Control state (pointers, count) is reset asynchronously; the storage and
// the head register are not reset.
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset
//   push_i       in   write push_data_i at the tail this cycle
//   push_data_i  in   WIDTH  data to push
//   pop_i        in   consumer ready; pops the head when the FIFO is non-empty
//   valid_o      out  FIFO non-empty, head_o is valid
//   head_o       out  WIDTH  oldest entry
//   count_o      out  current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module bram1be_rsp_fifo
    import bram1be_client_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PW = ptr_width(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_load;
    logic             do_pop;

    assign do_pop     = pop_i && (count_q != '0);
    assign rd_ptr_nxt = rd_ptr_q + PW'(1);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CW'(push_i) - CW'(do_pop);
        head_load = 1'b0;
        head_d    = push_data_i;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop) rd_ptr_d = rd_ptr_nxt;
        // The head register always mirrors mem_q[rd_ptr_q]. After a pop the
        // next entry is already in storage when at least two were held;
        // otherwise an incoming push lands straight in the head.
        if (do_pop && (count_q >= CW'(2))) begin
            head_load = 1'b1;
            head_d    = mem_q[rd_ptr_nxt];
        end else if (push_i && ((count_q == '0) || (do_pop && (count_q == CW'(1))))) begin
            head_load = 1'b1;
            head_d    = push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i)    mem_q[wr_ptr_q] <= push_data_i;
        if (head_load) head_q          <= head_d;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = head_q;
    assign count_o = count_q;

    // The client reserves a slot for every outstanding read, so a push into
    // a full FIFO without a simultaneous pop means the credit logic is broken.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !do_pop && (count_q == CW'(DEPTH))));

endmodule : bram1be_rsp_fifo

// File: rtl/bram1be_client.sv
// -----------------------------------------------------------------------------
// bram1be_client
// Drives a single-ported byte-enabled BRAM from a valid/ready request stream
// and returns read data on a valid/ready response stream, hiding the BRAM's
// fixed read latency behind an in-flight shift register and a credit-guarded
// response FIFO.
//
// Handshake: a transfer happens on a rising CLK edge where VALID and READY are
// both high. REQ_READY is a function of registered state only (never of
// REQ_VALID, REQ_WE or RSP_READY); RSP_VALID stays high with RSP_DATA stable
// until RSP_READY is seen.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   REQ_VALID/READY     request handshake
//   REQ_WE              byte enables, all-zero means read
//   REQ_ADDR, REQ_DATA  word address, write data
//   RSP_VALID/READY     response handshake
//   RSP_DATA            read data (FIFO head)
//   BRAM_EN/WE/ADDR/DI  to the BRAM port
//   BRAM_DO             from the BRAM port
//   IDLE                no reads in flight and response FIFO empty
// -----------------------------------------------------------------------------
module bram1be_client
    import bram1be_client_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 8,
    parameter int CHUNKSIZE  = 8,
    parameter int WE_WIDTH   = 1,
    parameter int PIPELINED  = 0,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [WE_WIDTH-1:0]   REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  BRAM_EN,
    output logic [WE_WIDTH-1:0]   BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DI,
    input  logic [DATA_WIDTH-1:0] BRAM_DO,
    output logic                  IDLE
);

    localparam int LAT = 1 + PIPELINED;
    localparam int PW  = ptr_width(RESP_DEPTH);
    localparam int CW  = PW + 1;
    localparam int RW  = CW + 1;

    if (DATA_WIDTH != WE_WIDTH * CHUNKSIZE) begin : g_bad_width
        $error("bram1be_client: DATA_WIDTH must equal WE_WIDTH*CHUNKSIZE");
    end
    if ((RESP_DEPTH < 2) || ((RESP_DEPTH & (RESP_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("bram1be_client: RESP_DEPTH must be a power of two, at least 2");
    end

    logic           active_q, active_d;
    logic [LAT-1:0] inflight_q, inflight_d;
    logic [CW-1:0]  fifo_count;
    logic [RW-1:0]  reserved;
    logic           accept;
    logic           rd_accept;
    logic           push;

    // Every outstanding read owns one FIFO slot from acceptance until it is
    // popped, so the FIFO cannot overflow. active_q holds READY low while in
    // reset and for the partial cycle before the first edge after release.
    assign reserved  = RW'(fifo_count) + RW'($countones(inflight_q));
    assign REQ_READY = active_q && (reserved < RW'(RESP_DEPTH));

    assign accept    = REQ_VALID && REQ_READY;
    assign rd_accept = accept && (REQ_WE == '0);
    assign push      = inflight_q[LAT-1];

    assign BRAM_EN   = accept;
    assign BRAM_WE   = accept ? REQ_WE : '0;
    assign BRAM_ADDR = REQ_ADDR;
    assign BRAM_DI   = REQ_DATA;

    always_comb begin
        active_d   = 1'b1;
        // Bit k set means a read accepted k+1 edges ago; bit LAT-1 marks the
        // cycle in which BRAM_DO carries that read's data.
        inflight_d = LAT'({inflight_q, rd_accept});
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            active_q   <= 1'b0;
            inflight_q <= '0;
        end else begin
            active_q   <= active_d;
            inflight_q <= inflight_d;
        end
    end

    bram1be_rsp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .push_i      (push),
        .push_data_i (BRAM_DO),
        .pop_i       (RSP_READY),
        .valid_o     (RSP_VALID),
        .head_o      (RSP_DATA),
        .count_o     (fifo_count)
    );

    assign IDLE = (inflight_q == '0) && (fifo_count == '0);

endmodule : bram1be_client

// File: tb/tb_bram1be_client.sv
// -----------------------------------------------------------------------------
// tb_bram1be_client
// Directed and randomized bench for bram1be_client with a behavioural BRAM.
// The reference model is a shadow memory plus an ordered queue of outstanding
// reads (data and acceptance cycle); READY, IDLE, RSP_VALID and read data are
// all derived from that queue and the read latency.
// -----------------------------------------------------------------------------
module tb_bram1be_client;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int CH    = 8;
  localparam int WEW   = 4;
  localparam int PIPE  = 1;
  localparam int DEPTH = 4;
  localparam int LAT   = 1 + PIPE;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [WEW-1:0] req_we = '0;
  logic [AW-1:0]  req_addr = '0;
  logic [DW-1:0]  req_data = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DW-1:0]  rsp_data;
  logic           bram_en;
  logic [WEW-1:0] bram_we;
  logic [AW-1:0]  bram_addr;
  logic [DW-1:0]  bram_di;
  logic [DW-1:0]  bram_do;
  logic           idle;

  bram1be_client #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CHUNKSIZE  (CH),
    .WE_WIDTH   (WEW),
    .PIPELINED  (PIPE),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .REQ_VALID (req_valid),
    .REQ_READY (req_ready),
    .REQ_WE    (req_we),
    .REQ_ADDR  (req_addr),
    .REQ_DATA  (req_data),
    .RSP_VALID (rsp_valid),
    .RSP_READY (rsp_ready),
    .RSP_DATA  (rsp_data),
    .BRAM_EN   (bram_en),
    .BRAM_WE   (bram_we),
    .BRAM_ADDR (bram_addr),
    .BRAM_DI   (bram_di),
    .BRAM_DO   (bram_do),
    .IDLE      (idle)
  );

  // ---------------------------------------------------------------- BRAM model
  logic [DW-1:0] bram_mem [16];
  logic [DW-1:0] bram_rd_q;
  logic [DW-1:0] bram_rd_q2;

  always @(posedge clk) begin
    if (bram_en) begin
      bram_rd_q <= bram_mem[bram_addr];
      for (int i = 0; i < WEW; i++)
        if (bram_we[i]) bram_mem[bram_addr][i*CH +: CH] <= bram_di[i*CH +: CH];
    end
    bram_rd_q2 <= bram_rd_q;
  end
  assign bram_do = (PIPE != 0) ? bram_rd_q2 : bram_rd_q;

  // ---------------------------------------------------------------- scoreboard
  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  logic [DW-1:0] shadow [16];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int rsp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called once per cycle at the falling edge: compares the DUT with the
  // model, then applies this cycle's accept/pop to the model.
  task automatic sample();
    logic          exp_ready;
    logic          exp_en;
    logic          exp_rv;
    logic [DW-1:0] e;
    int            c;
    if (rst_n !== 1'b1) return;
    exp_ready = (cyc > rel_cyc) && (exp_q.size() < DEPTH);
    exp_rv    = (exp_q.size() != 0) && ((cyc - acc_q[0]) >= LAT + 1);
    exp_en    = req_valid && exp_ready;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("idle", 32'(idle), 32'(exp_q.size() == 0));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("bram_en", 32'(bram_en), 32'(exp_en));
    check("bram_we", 32'(bram_we), 32'(exp_en ? req_we : 4'h0));
    if (exp_en) begin
      check("bram_addr", 32'(bram_addr), 32'(req_addr));
      check("bram_di", bram_di, req_data);
    end
    if (rsp_valid && rsp_ready && (exp_q.size() != 0)) begin
      e = exp_q.pop_front();
      c = acc_q.pop_front();
      check("rsp_data", rsp_data, e);
      rsp_cnt++;
    end
    if (exp_en) begin
      if (req_we == '0) begin
        exp_q.push_back(shadow[req_addr]);
        acc_q.push_back(cyc);
      end else begin
        for (int i = 0; i < WEW; i++)
          if (req_we[i]) shadow[req_addr][i*CH +: CH] = req_data[i*CH +: CH];
      end
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic next_cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req(input logic [WEW-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_data  = data;
    for (int n = 0; n < 64 && !req_ready; n++) next_cycle();
    check("req_accept_timeout", 32'(req_ready), 32'd1);
    next_cycle();
    req_valid = 1'b0;
    req_we    = '0;
  endtask

  task automatic wait_rsp();
    for (int n = 0; n < 32 && !rsp_valid; n++) next_cycle();
    check("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 64 && !(idle && exp_q.size() == 0); n++) next_cycle();
    check("drain_idle", 32'(idle), 32'd1);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int t;
    int acc;
    int c0;

    // Reset held: outputs at reset values even with a write presented.
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    req_valid = 1'b1;
    req_we    = 4'hF;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_bram_en", 32'(bram_en), 32'd0);
    check("rst_bram_we", 32'(bram_we), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    req_valid = 1'b0;
    req_we    = '0;
    next_cycle();
    next_cycle();
    rst_n   = 1'b1;
    rel_cyc = cyc;
    check("rel_ready_before_edge", 32'(req_ready), 32'd0);
    next_cycle();
    check("rel_ready", 32'(req_ready), 32'd1);
    check("rel_idle", 32'(idle), 32'd1);
    check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rel_bram_en", 32'(bram_en), 32'd0);

    // Fill the whole BRAM so every later read has defined data.
    rsp_ready = 1'b1;
    for (int a = 0; a < 16; a++) req(4'hF, 4'(a), $urandom);

    // Write then read the same address next cycle.
    req(4'hF, 4'd5, 32'h0000_00A5);
    t = cyc;
    req(4'h0, 4'd5, 32'h0);
    wait_rsp();
    check("raw_latency", 32'(cyc - t), 32'(LAT + 1));
    check("raw_data", rsp_data, 32'h0000_00A5);
    drain();

    // Partial byte-enable write merges with the existing word.
    req(4'hF, 4'd3, 32'h1122_3344);
    req(4'b0010, 4'd3, 32'h0000_BB00);
    req(4'h0, 4'd3, 32'h0);
    wait_rsp();
    check("be_merge", rsp_data, 32'h1122_BB44);
    drain();

    // Back-to-back reads with the consumer always ready.
    c0 = rsp_cnt;
    for (int a = 0; a < 8; a++) begin
      check("b2b_ready", 32'(req_ready), 32'd1);
      req(4'h0, 4'(a), 32'h0);
    end
    drain();
    check("b2b_count", 32'(rsp_cnt - c0), 32'd8);

    // Backpressure: only DEPTH reads fit, one pop frees one credit.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = '0;
    acc = 0;
    for (int n = 0; n < 8; n++) begin
      req_addr = 4'($urandom_range(0, 15));
      if (req_ready) acc++;
      next_cycle();
    end
    check("bp_accepts", 32'(acc), 32'(DEPTH));
    check("bp_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    next_cycle();
    rsp_ready = 1'b0;
    check("bp_credit_back", 32'(req_ready), 32'd1);
    next_cycle();
    check("bp_ready_relow", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      next_cycle();
    end
    drain();

    // Randomized mixed traffic with random consumer stalls.
    for (int n = 0; n < 400; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      req_addr  = 4'($urandom_range(0, 15));
      req_data  = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    drain();

    // Asynchronous reset with two reads in flight and two queued.
    req(4'hF, 4'd9, 32'hCAFE_F00D);
    drain();
    rsp_ready = 1'b0;
    for (int a = 1; a <= 4; a++) req(4'h0, 4'(a), 32'h0);
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    check("pre_rst_idle", 32'(idle), 32'd0);
    req_valid = 1'b1;
    req_we    = 4'hF;
    req_addr  = 4'd2;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_bram_en", 32'(bram_en), 32'd0);
    check("arst_bram_we", 32'(bram_we), 32'd0);
    check("arst_idle", 32'(idle), 32'd1);
    exp_q.delete();
    acc_q.delete();
    req_valid = 1'b0;
    req_we    = '0;
    next_cycle();
    next_cycle();
    rst_n   = 1'b1;
    rel_cyc = cyc;
    next_cycle();
    c0 = rsp_cnt;
    rsp_ready = 1'b1;
    for (int n = 0; n < 10; n++) next_cycle();
    check("post_rst_no_rsp", 32'(rsp_cnt - c0), 32'd0);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    req(4'h0, 4'd9, 32'h0);
    wait_rsp();
    check("post_rst_old_write", rsp_data, 32'hCAFE_F00D);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_bram1be_client
